// File: rtl/bf_io_fifo.sv
// Buffered character input channel feeding the brainfuck core's ',' port: circular queue
// plus a strobe FSM. Define BF_IO_FIFO_ECHO_EN to add the one-cycle-delayed echo outputs.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for rd_req with a non-empty buffer
// PULSE   | rd_pulse high, rd_data holds the dequeued character
// HOLDOFF | forced gap so a late-dropping rd_req cannot take two chars

module bf_io_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    input  logic                  rd_req,
    output logic                  rd_pulse,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
`ifdef BF_IO_FIFO_ECHO_EN
    output logic                  echo_pulse,
    output logic [DATA_WIDTH-1:0] echo_data,
`endif
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_HOLDOFF
    } rd_state_t;

    rd_state_t             state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [DEPTH_LOG2:0]   count_nxt;
    logic                  wr_ok;
    logic                  deq;

    // full/empty are the registered flags, so a write seen while full is dropped
    // even if a dequeue frees a slot on the same edge.
    assign wr_ok = wr_en && !full;
    assign deq   = (state == S_IDLE) && rd_req && !empty;

    always_comb begin
        count_nxt = count;
        if (wr_ok && !deq)
            count_nxt = count + CNT_ONE;
        else if (!wr_ok && deq)
            count_nxt = count - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_ok)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == CNT_ZERO);
            if (wr_ok)
                wptr <= wptr + PTR_ONE;
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            rptr     <= '0;
            rd_pulse <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_pulse <= 1'b0;
                    if (deq) begin
                        rd_data  <= mem[rptr];
                        rptr     <= rptr + PTR_ONE;
                        rd_pulse <= 1'b1;
                        state    <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    rd_pulse <= 1'b0;
                    state    <= S_HOLDOFF;
                end
                S_HOLDOFF: begin
                    rd_pulse <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    rd_pulse <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BF_IO_FIFO_ECHO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_pulse <= 1'b0;
            echo_data  <= '0;
        end else begin
            echo_pulse <= rd_pulse;
            echo_data  <= rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_bf_io_fifo.sv
// Scoreboard bench for bf_io_fifo at depth 4: stimulus pushes expected characters,
// a negedge monitor pops and checks every rd_pulse.

module tb_bf_io_fifo;

    localparam int DW = 8;
    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          full;
    logic          rd_req = 1'b0;
    logic          rd_pulse;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic [DL:0]   count;
    logic          overflow;
`ifdef BF_IO_FIFO_ECHO_EN
    logic          echo_pulse;
    logic [DW-1:0] echo_data;
`endif

    bf_io_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_req   (rd_req),
        .rd_pulse (rd_pulse),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count),
`ifdef BF_IO_FIFO_ECHO_EN
        .echo_pulse (echo_pulse),
        .echo_data  (echo_data),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int        tests = 0;
    int        fails = 0;
    int        cyc = 0;
    logic [DW-1:0] exp_q[$];
    int        pulse_log[$];
    int        last_pulse = -100;
    logic      prev_pulse = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rd_pulse === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pulse: got data %02h, none expected (cycle %0d)", rd_data, cyc);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    fails++;
                    $display("FAIL rd_data: got %02h, expected %02h (cycle %0d)", rd_data, e, cyc);
                end
            end
            tests++;
            if (cyc - last_pulse < 3) begin
                fails++;
                $display("FAIL pulse_gap: got %0d cycles, expected >= 3", cyc - last_pulse);
            end
            last_pulse = cyc;
            pulse_log.push_back(cyc);
        end
`ifdef BF_IO_FIFO_ECHO_EN
        if (echo_pulse === 1'b1) begin
            tests++;
            if (!(prev_pulse === 1'b1 && echo_data === prev_data)) begin
                fails++;
                $display("FAIL echo: got data %02h prev_pulse %0b, expected data %02h after pulse", echo_data, prev_pulse, prev_data);
            end
        end
`endif
        prev_pulse = rd_pulse;
        prev_data  = rd_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic write(input logic [DW-1:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rd_req = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: %0d chars left, expected 0", name, exp_q.size());
        end
        repeat (6) tick();
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with writes attempted
        wr_en = 1'b1;
        wr_data = 8'h55;
        tick();
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_pulse", 32'(rd_pulse), 32'd0);

        // Single character with latency check
        write(8'h20, 1'b1);
        check("single_count", 32'(count), 32'd1);
        check("single_empty", 32'(empty), 32'd0);
        rd_req = 1'b1;
        tick();
        check("single_pulse", 32'(rd_pulse), 32'd1);
        check("single_data", 32'(rd_data), 32'h20);
        tick();
        check("single_pulse_end", 32'(rd_pulse), 32'd0);
        drain("single");
        check("single_count_after", 32'(count), 32'd0);
        check("single_empty_after", 32'(empty), 32'd1);
        check("single_hold", 32'(rd_data), 32'h20);

        // Fill and overflow
        write(8'h41, 1'b1);
        write(8'h42, 1'b1);
        write(8'h43, 1'b1);
        check("fill_full_3", 32'(full), 32'd0);
        write(8'h44, 1'b1);
        check("fill_full_4", 32'(full), 32'd1);
        check("fill_count_4", 32'(count), 32'd4);
        check("fill_ovf_pre", 32'(overflow), 32'd0);
        write(8'h45, 1'b0);
        check("fill_ovf", 32'(overflow), 32'd1);
        check("fill_count_5", 32'(count), 32'd4);
        pulse_log.delete();
        drain("fill");
        check("fill_npulses", 32'(pulse_log.size()), 32'd4);
        for (int i = 1; i < pulse_log.size(); i++)
            check("fill_spacing", 32'(pulse_log[i] - pulse_log[i-1]), 32'd3);
        check("fill_ovf_sticky", 32'(overflow), 32'd1);
        check("fill_empty", 32'(empty), 32'd1);

        // Wrap-around: 10 rounds of 3 writes then drain
        for (int r = 0; r < 10; r++) begin
            write(8'(8'h60 + 3 * r), 1'b1);
            write(8'(8'h61 + 3 * r), 1'b1);
            write(8'(8'h62 + 3 * r), 1'b1);
            check("wrap_count", 32'(count), 32'd3);
            drain("wrap");
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // Simultaneous write and dequeue at count 2
        write(8'hA0, 1'b1);
        write(8'hA1, 1'b1);
        rd_req  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hA2;
        exp_q.push_back(8'hA2);
        tick();
        wr_en  = 1'b0;
        rd_req = 1'b0;
        check("simul_count", 32'(count), 32'd2);
        check("simul_pulse", 32'(rd_pulse), 32'd1);
        drain("simul");

        // Write while full and dequeue on the same edge
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);
        write(8'hD0, 1'b1);
        write(8'hD1, 1'b1);
        write(8'hD2, 1'b1);
        write(8'hD3, 1'b1);
        rd_req  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hDF;
        tick();
        wr_en = 1'b0;
        check("fullsim_count", 32'(count), 32'd3);
        check("fullsim_ovf", 32'(overflow), 32'd1);
        check("fullsim_full", 32'(full), 32'd0);
        drain("fullsim");

        // No bypass: write into empty buffer with rd_req already high
        rd_req = 1'b1;
        write(8'hB7, 1'b1);
        check("nobypass_pulse", 32'(rd_pulse), 32'd0);
        tick();
        check("nobypass_pulse_next", 32'(rd_pulse), 32'd1);
        drain("nobypass");

        // Reset during PULSE with 3 entries still queued
        write(8'hE0, 1'b1);
        write(8'hE1, 1'b0);
        write(8'hE2, 1'b0);
        write(8'hE3, 1'b0);
        rd_req = 1'b1;
        tick();
        check("midrst_in_pulse", 32'(rd_pulse), 32'd1);
        check("midrst_count_pre", 32'(count), 32'd3);
        reset  = 1'b1;
        rd_req = 1'b0;
        tick();
        check("midrst_pulse", 32'(rd_pulse), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_count", 32'(count), 32'd0);
`ifdef BF_IO_FIFO_ECHO_EN
        check("midrst_echo", 32'(echo_pulse), 32'd0);
`endif
        reset  = 1'b0;
        rd_req = 1'b1;
        repeat (8) tick();
        rd_req = 1'b0;
        check("midrst_nothing_left", 32'(empty), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
